// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus bridge.
//   PERIPHERAL_DATA_WIDTH : width of every peripheral data bus
//   ERROR_READ_DATA       : read data returned with a bus error
//   bridgeState_t         : bridge FSM encodings (IDLE, ACCESS, RESPOND)
package peripheral_bus_pkg;

    localparam int PERIPHERAL_DATA_WIDTH = 32;
    localparam logic [PERIPHERAL_DATA_WIDTH-1:0] ERROR_READ_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_ACCESS  = 2'd1,
        STATE_RESPOND = 2'd2
    } bridgeState_t;

endpackage

// File: rtl/peripheral_bus_bridge.sv
// Wishbone classic slave driving the shared peripheral bus.
// One request is registered in IDLE, run on the peripheral bus in ACCESS with a
// we/oe strobe, and answered with a one-cycle ack or error in RESPOND.
//
// Handshake: a request is accepted in IDLE when wb_cyc_i & wb_stb_i; wb_stall_o is
// high in every other state. The master keeps cyc/stb up until it sees exactly one
// of wb_ack_o / wb_error_o; dropping wb_cyc_i during ACCESS aborts silently.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i       Wishbone cycle / strobe
//   wb_we_i, wb_sel_i        write enable, byte lanes
//   wb_adr_i, wb_data_i      byte address, write data
//   wb_ack_o, wb_error_o     completion / error pulses
//   wb_stall_o               low only in IDLE
//   wb_data_o                read data, valid with ack/error, held otherwise
//   peripheralBus_*          registered address/lanes/write data, we/oe strobes
//   peripheralBus_dataRead   OR of peripheral read data
//   peripheralBus_busy       a peripheral needs more cycles
//   requestOutput            a peripheral claimed the read
module peripheral_bus_bridge
    import peripheral_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [3:0]                       wb_sel_i,
    input  logic [ADDRESS_WIDTH-1:0]         wb_adr_i,
    input  logic [PERIPHERAL_DATA_WIDTH-1:0] wb_data_i,
    output logic                             wb_ack_o,
    output logic                             wb_error_o,
    output logic                             wb_stall_o,
    output logic [PERIPHERAL_DATA_WIDTH-1:0] wb_data_o,
    output logic                             peripheralBus_we,
    output logic                             peripheralBus_oe,
    output logic [ADDRESS_WIDTH-1:0]         peripheralBus_address,
    output logic [3:0]                       peripheralBus_byteSelect,
    output logic [PERIPHERAL_DATA_WIDTH-1:0] peripheralBus_dataWrite,
    input  logic [PERIPHERAL_DATA_WIDTH-1:0] peripheralBus_dataRead,
    input  logic                             peripheralBus_busy,
    input  logic                             requestOutput
);

    // A one-cycle timeout still needs a 1-bit counter.
    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    bridgeState_t             state;
    bridgeState_t             nextState;
    logic                     latchedWe;
    logic                     respondError;
    logic [COUNTER_WIDTH-1:0] timeoutCount;

    logic doCapture;
    logic doComplete;
    logic doTimeout;
    logic doAbort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Priority in ACCESS: abort, then completion, then timeout (completion wins
    // over a timeout in the same cycle). A read with busy=0 but no requestOutput
    // is unclaimed, not complete.
    always_comb begin
        nextState  = state;
        doCapture  = 1'b0;
        doComplete = 1'b0;
        doTimeout  = 1'b0;
        doAbort    = 1'b0;
        unique case (state)
            STATE_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    doCapture = 1'b1;
                    nextState = STATE_ACCESS;
                end
            end
            STATE_ACCESS: begin
                if (!wb_cyc_i) begin
                    doAbort   = 1'b1;
                    nextState = STATE_IDLE;
                end else if (!peripheralBus_busy && (latchedWe || requestOutput)) begin
                    doComplete = 1'b1;
                    nextState  = STATE_RESPOND;
                end else if (timeoutCount == TIMEOUT_LAST) begin
                    doTimeout = 1'b1;
                    nextState = STATE_RESPOND;
                end
            end
            STATE_RESPOND: begin
                nextState = STATE_IDLE;
            end
            default: begin
                nextState = STATE_IDLE;
            end
        endcase
    end

    // Strobes and responses decode only registered state, so there is no
    // combinational path from the Wishbone inputs to the peripheral bus.
    always_comb begin
        wb_stall_o       = (state != STATE_IDLE);
        peripheralBus_we = (state == STATE_ACCESS) && latchedWe;
        peripheralBus_oe = (state == STATE_ACCESS) && !latchedWe;
        wb_ack_o         = (state == STATE_RESPOND) && !respondError;
        wb_error_o       = (state == STATE_RESPOND) && respondError;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latchedWe                <= 1'b0;
            respondError             <= 1'b0;
            timeoutCount             <= '0;
            wb_data_o                <= '0;
            peripheralBus_address    <= '0;
            peripheralBus_byteSelect <= '0;
            peripheralBus_dataWrite  <= '0;
        end else begin
            if (doCapture) begin
                latchedWe                <= wb_we_i;
                peripheralBus_address    <= wb_adr_i;
                peripheralBus_byteSelect <= wb_sel_i;
                peripheralBus_dataWrite  <= wb_data_i;
            end else if (doAbort) begin
                latchedWe                <= 1'b0;
                peripheralBus_address    <= '0;
                peripheralBus_byteSelect <= '0;
                peripheralBus_dataWrite  <= '0;
            end

            // Counts cycles spent in ACCESS; zero whenever ACCESS is left.
            if ((state == STATE_ACCESS) && (nextState == STATE_ACCESS)) begin
                timeoutCount <= timeoutCount + 1'b1;
            end else begin
                timeoutCount <= '0;
            end

            // Writes leave wb_data_o untouched so it keeps the last read value.
            if (doComplete) begin
                respondError <= 1'b0;
                if (!latchedWe) begin
                    wb_data_o <= peripheralBus_dataRead;
                end
            end else if (doTimeout) begin
                respondError <= 1'b1;
                wb_data_o    <= ERROR_READ_DATA;
            end
        end
    end

endmodule
